// File: rtl/tty_iot_ctrl.sv
// PDP-8 console teleprinter controller: decodes keyboard/printer IOTs, holds
// KBUF and the KF/TF/IE flags, and hands printer characters to the UART.
module tty_iot_ctrl #(
  parameter logic [5:0] KBD_DEV  = 6'o03,
  parameter logic [5:0] TTY_DEV  = 6'o04,
  parameter logic       IE_RESET = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_iot_stb,
  input  logic [5:0]  i_iot_dev,
  input  logic [2:0]  i_iot_op,
  input  logic [11:0] i_ac_in,
  output logic        o_iot_ack,
  output logic        o_skip,
  output logic        o_ac_clr,
  output logic [11:0] o_ac_or,
  output logic        o_irq,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic        i_tx_done,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_rx_ovr
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY} tx_state_t;

  tx_state_t   r_state;
  logic        r_kf, r_tf, r_ie, r_rx_ovr;
  logic [7:0]  r_kbuf, r_tx_data;
  logic        r_tx_valid, r_iot_ack, r_skip, r_ac_clr, r_irq;
  logic [11:0] r_ac_or;

  logic        w_kbd_hit, w_tty_hit;
  logic        w_skip, w_ac_clr;
  logic [11:0] w_ac_or;
  logic        w_kf_clr, w_ie_wr, w_tf_set, w_tf_clr, w_print;
  logic        w_tx_done_set;
  logic        w_unused_ac;

  assign w_unused_ac = ^i_ac_in[11:8];

  // IOT decode; flags and KBUF reported from pre-update register state
  always_comb begin
    w_kbd_hit = i_iot_stb && (i_iot_dev == KBD_DEV);
    w_tty_hit = i_iot_stb && (i_iot_dev == TTY_DEV);
    w_skip    = 1'b0;
    w_ac_clr  = 1'b0;
    w_ac_or   = 12'h000;
    w_kf_clr  = 1'b0;
    w_ie_wr   = 1'b0;
    w_tf_set  = 1'b0;
    w_tf_clr  = 1'b0;
    w_print   = 1'b0;
    if (w_kbd_hit) begin
      case (i_iot_op)
        3'd0: w_kf_clr = 1'b1;
        3'd5: w_ie_wr  = 1'b1;
        default: begin
          w_skip   = i_iot_op[0] & r_kf;
          w_kf_clr = i_iot_op[1];
          w_ac_clr = i_iot_op[1];
          w_ac_or  = i_iot_op[2] ? {4'b0000, r_kbuf} : 12'h000;
        end
      endcase
    end
    if (w_tty_hit) begin
      case (i_iot_op)
        3'd0: w_tf_set = 1'b1;
        3'd5: w_skip   = r_tf | r_kf;
        default: begin
          w_skip   = i_iot_op[0] & r_tf;
          w_tf_clr = i_iot_op[1];
          w_print  = i_iot_op[2];
        end
      endcase
    end
  end

  assign w_tx_done_set = (r_state == S_BUSY) && i_tx_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_kf       <= 1'b0;
      r_tf       <= 1'b0;
      r_ie       <= IE_RESET;
      r_kbuf     <= 8'h00;
      r_rx_ovr   <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_iot_ack  <= 1'b0;
      r_skip     <= 1'b0;
      r_ac_clr   <= 1'b0;
      r_ac_or    <= 12'h000;
      r_irq      <= 1'b0;
    end else begin
      r_iot_ack <= w_kbd_hit | w_tty_hit;
      r_skip    <= w_skip;
      r_ac_clr  <= w_ac_clr;
      r_ac_or   <= w_ac_or;
      r_irq     <= r_ie & (r_kf | r_tf);

      if (w_ie_wr) r_ie <= i_ac_in[0];

      // Hardware set of KF wins over a same-cycle software clear
      if (i_rx_valid) begin
        r_kbuf <= i_rx_data;
        r_kf   <= 1'b1;
        if (r_kf && !w_kf_clr) r_rx_ovr <= 1'b1;
      end else if (w_kf_clr) begin
        r_kf <= 1'b0;
      end

      if (w_tx_done_set || w_tf_set) r_tf <= 1'b1;
      else if (w_tf_clr)             r_tf <= 1'b0;

      // Print requests outside IDLE are dropped
      case (r_state)
        S_IDLE: begin
          if (w_print) begin
            r_tx_data  <= i_ac_in[7:0];
            r_tx_valid <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_tx_ready) begin
            r_tx_valid <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_tx_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_iot_ack  = r_iot_ack;
  assign o_skip     = r_skip;
  assign o_ac_clr   = r_ac_clr;
  assign o_ac_or    = r_ac_or;
  assign o_irq      = r_irq;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_rx_ovr   = r_rx_ovr;

endmodule

// File: tb/tb_tty_iot_ctrl.sv
// Bench for tty_iot_ctrl: directed scenarios plus random traffic, checked
// every cycle against a flag/transmitter reference model.
module tb_tty_iot_ctrl;

  logic        clk = 1'b0;
  logic        rst, stb, rdy, done, rxv;
  logic [5:0]  dev;
  logic [2:0]  op;
  logic [11:0] ac;
  logic [7:0]  rxd;
  logic        o_iot_ack, o_skip, o_ac_clr, o_irq, o_tx_valid, o_rx_ovr;
  logic [11:0] o_ac_or;
  logic [7:0]  o_tx_data;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit         m_kf, m_tf, m_ie, m_ovr, m_offered, m_busy;
  bit  [7:0]  m_kbuf, m_txd;
  bit         e_ack, e_skip, e_clr, e_irq;
  bit  [11:0] e_or;

  always #5 clk = ~clk;

  tty_iot_ctrl dut (
    .i_clk(clk), .i_reset(rst), .i_iot_stb(stb), .i_iot_dev(dev),
    .i_iot_op(op), .i_ac_in(ac), .o_iot_ack(o_iot_ack), .o_skip(o_skip),
    .o_ac_clr(o_ac_clr), .o_ac_or(o_ac_or), .o_irq(o_irq),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(rdy),
    .i_tx_done(done), .i_rx_data(rxd), .i_rx_valid(rxv), .o_rx_ovr(o_rx_ovr)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    rst = 0; stb = 0; dev = 6'o00; op = 3'd0; ac = 12'h000;
    rdy = 0; done = 0; rxv = 0; rxd = 8'h00;
  endtask

  // Advance the model by one clock using the inputs as they stood at the edge
  task automatic model_step();
    bit kclr, ieset, tset, tclr, prn, kh, th, done_ev;
    kclr = 0; ieset = 0; tset = 0; tclr = 0; prn = 0;
    if (rst) begin
      m_kf = 0; m_tf = 0; m_ie = 1; m_ovr = 0; m_offered = 0; m_busy = 0;
      m_kbuf = 0; m_txd = 0;
      e_ack = 0; e_skip = 0; e_clr = 0; e_or = 0; e_irq = 0;
      return;
    end
    kh = stb && dev == 6'o03;
    th = stb && dev == 6'o04;
    e_ack = kh || th; e_skip = 0; e_clr = 0; e_or = 0;
    e_irq = m_ie && (m_kf || m_tf);
    if (kh) begin
      case (op)
        3'd0: kclr = 1;
        3'd1: e_skip = m_kf;
        3'd2: begin kclr = 1; e_clr = 1; end
        3'd3: begin e_skip = m_kf; kclr = 1; e_clr = 1; end
        3'd4: e_or = {4'h0, m_kbuf};
        3'd5: ieset = 1;
        3'd6: begin kclr = 1; e_clr = 1; e_or = {4'h0, m_kbuf}; end
        3'd7: begin e_skip = m_kf; kclr = 1; e_clr = 1; e_or = {4'h0, m_kbuf}; end
      endcase
    end
    if (th) begin
      case (op)
        3'd0: tset = 1;
        3'd1: e_skip = m_tf;
        3'd2: tclr = 1;
        3'd3: begin e_skip = m_tf; tclr = 1; end
        3'd4: prn = 1;
        3'd5: e_skip = m_tf || m_kf;
        3'd6: begin tclr = 1; prn = 1; end
        3'd7: begin e_skip = m_tf; tclr = 1; prn = 1; end
      endcase
    end
    if (ieset) m_ie = ac[0];
    if (rxv) begin
      if (m_kf && !kclr) m_ovr = 1;
      m_kf = 1; m_kbuf = rxd;
    end else if (kclr) m_kf = 0;
    done_ev = m_busy && done;
    if (m_offered) begin
      if (rdy) begin m_offered = 0; m_busy = 1; end
    end else if (m_busy) begin
      if (done) m_busy = 0;
    end else if (prn) begin
      m_offered = 1; m_txd = ac[7:0];
    end
    if (done_ev || tset) m_tf = 1;
    else if (tclr) m_tf = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    chk("iot_ack",  12'(o_iot_ack),  12'(e_ack));
    chk("skip",     12'(o_skip),     12'(e_skip));
    chk("ac_clr",   12'(o_ac_clr),   12'(e_clr));
    chk("ac_or",    o_ac_or,         e_or);
    chk("irq",      12'(o_irq),      12'(e_irq));
    chk("tx_valid", 12'(o_tx_valid), 12'(m_offered));
    chk("tx_data",  12'(o_tx_data),  12'(m_txd));
    chk("rx_ovr",   12'(o_rx_ovr),   12'(m_ovr));
  endtask

  task automatic iot(input logic [5:0] d, input logic [2:0] o, input logic [11:0] a);
    stb = 1; dev = d; op = o; ac = a;
  endtask

  initial begin
    quiet();
    rst = 1; step(); step();
    rst = 0; step();
    chk("reset_irq", 12'(o_irq), 12'h0);
    chk("reset_ack", 12'(o_iot_ack), 12'h0);

    // keyboard receive, skip and read
    rxv = 1; rxd = 8'h41; step(); quiet(); step();
    chk("irq_after_rx", 12'(o_irq), 12'h1);
    iot(6'o03, 3'd1, 12'h000); step(); quiet();
    chk("ksf_skip", 12'(o_skip), 12'h1);
    iot(6'o03, 3'd6, 12'h000); step(); quiet();
    chk("krb_or", o_ac_or, 12'h041);
    chk("krb_clr", 12'(o_ac_clr), 12'h1);
    step(); step();
    chk("irq_after_krb", 12'(o_irq), 12'h0);

    // print with stalled ready, then dropped second print while busy
    iot(6'o04, 3'd6, 12'h0C8); step(); quiet();
    chk("tls_data", 12'(o_tx_data), 12'h0C8);
    for (int i = 0; i < 5; i++) step();
    chk("tx_hold", 12'(o_tx_valid), 12'h1);
    rdy = 1; step(); rdy = 0;
    iot(6'o04, 3'd4, 12'h055); step(); quiet(); step();
    chk("tx_drop", 12'(o_tx_data), 12'h0C8);
    done = 1; step(); done = 0;
    iot(6'o04, 3'd1, 12'h000); step(); quiet();
    chk("tsf_skip", 12'(o_skip), 12'h1);

    // overrun and simultaneous receive with KRB
    rxv = 1; rxd = 8'h31; step(); rxd = 8'h32; step(); quiet(); step();
    chk("ovr", 12'(o_rx_ovr), 12'h1);
    iot(6'o03, 3'd6, 12'h000); rxv = 1; rxd = 8'h77; step(); quiet();
    chk("krb_old_kbuf", o_ac_or, 12'h032);
    iot(6'o03, 3'd1, 12'h000); step(); quiet();
    chk("kf_survives", 12'(o_skip), 12'h1);
    iot(6'o03, 3'd6, 12'h000); step(); quiet();

    // interrupt enable control
    iot(6'o03, 3'd5, 12'hFFE); step(); quiet();
    iot(6'o04, 3'd0, 12'h000); step(); quiet(); step(); step();
    chk("irq_masked", 12'(o_irq), 12'h0);
    iot(6'o04, 3'd5, 12'h000); step(); quiet();
    chk("tsk_skip", 12'(o_skip), 12'h1);
    iot(6'o03, 3'd5, 12'h001); step(); quiet(); step(); step();
    chk("irq_enabled", 12'(o_irq), 12'h1);

    // TX_DONE beats a same-cycle TCF
    iot(6'o04, 3'd4, 12'h0AA); step(); quiet();
    rdy = 1; step(); rdy = 0;
    iot(6'o04, 3'd2, 12'h000); done = 1; step(); quiet();
    iot(6'o04, 3'd1, 12'h000); step(); quiet();
    chk("done_beats_tcf", 12'(o_skip), 12'h1);

    // reset while a character is offered
    iot(6'o04, 3'd6, 12'h0BB); step(); quiet();
    rst = 1; step(); rst = 0;
    chk("rst_tx_valid", 12'(o_tx_valid), 12'h0);
    iot(6'o05, 3'd1, 12'h000); step(); quiet();
    chk("foreign_dev", 12'(o_iot_ack), 12'h0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst  = ($urandom_range(0, 99) == 0);
      stb  = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0: dev = 6'o03;
        1: dev = 6'o04;
        2: dev = 6'o05;
        default: dev = 6'($urandom);
      endcase
      op   = 3'($urandom);
      ac   = 12'($urandom);
      rdy  = $urandom_range(0, 2) == 0;
      done = $urandom_range(0, 3) == 0;
      rxv  = $urandom_range(0, 7) == 0;
      rxd  = 8'($urandom);
      step();
    end
    quiet(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
